// File: rtl/sram_responder.sv
// sram_responder: clocked stand-in for the external 16-bit asynchronous SRAM.
// Defining SRAM_RESP_CHECK_EN compiles in the sticky protocol checker driving proto_err.
module sram_responder #(
  parameter int MEM_AW   = 12,
  parameter int READ_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [15:0] SRAM_DQ,
  input  logic [17:0] SRAM_ADDR,
  input  logic        SRAM_UB_N,
  input  logic        SRAM_LB_N,
  input  logic        SRAM_WE_N,
  input  logic        SRAM_CE_N,
  input  logic        SRAM_OE_N,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic        proto_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRIVE = 2'd3
  } state_t;

  localparam logic [2:0] LAT_INIT = 3'(READ_LAT);

  state_t              r_state;
  logic [2:0]          r_lat_cnt;
  logic [MEM_AW-1:0]   r_addr;
  logic [15:0]         r_wdata;
  logic                r_wub_n;
  logic                r_wlb_n;
  logic                r_oe_hi;
  logic                r_oe_lo;
  logic [15:0]         r_dq;
  logic [15:0]         r_rd_count;
  logic [15:0]         r_wr_count;
  logic [15:0]         r_mem [0:(1<<MEM_AW)-1];

  state_t              w_state_nxt;
  logic [2:0]          w_lat_nxt;
  logic                w_latch_addr;
  logic                w_capture;
  logic                w_commit;
  logic                w_drive_entry;
  logic                w_drive_hold;
  logic [MEM_AW-1:0]   w_addr;
  logic                w_ce;
  logic                w_we;
  logic                w_oe;
  logic                w_addr_chg;
  logic                w_unused_addr_hi;

  // Upper address bits are deliberately ignored so addresses alias.
  assign w_addr           = SRAM_ADDR[MEM_AW-1:0];
  assign w_unused_addr_hi = &{1'b0, SRAM_ADDR[17:MEM_AW]};
  assign w_ce             = ~SRAM_CE_N;
  assign w_we             = ~SRAM_WE_N;
  assign w_oe             = ~SRAM_OE_N;
  assign w_addr_chg       = (w_addr != r_addr);

  // Next-state and per-cycle control decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_lat_nxt    = 3'd0;
    w_latch_addr = 1'b0;
    w_capture    = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ce && w_we) begin
          w_state_nxt  = ST_WRITE;
          w_capture    = 1'b1;
          w_latch_addr = 1'b1;
        end else if (w_ce && w_oe) begin
          w_latch_addr = 1'b1;
          if (LAT_INIT == 3'd0) begin
            w_state_nxt = ST_DRIVE;
          end else begin
            w_state_nxt = ST_READ;
            w_lat_nxt   = LAT_INIT;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (w_ce && w_we) begin
          w_capture    = 1'b1;
          w_latch_addr = 1'b1;
        end else begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_READ: begin
        if (!w_ce) begin
          w_state_nxt = ST_IDLE;
        end else if (w_we) begin
          w_state_nxt  = ST_WRITE;
          w_capture    = 1'b1;
          w_latch_addr = 1'b1;
        end else if (!w_oe) begin
          w_state_nxt = ST_IDLE;
        end else if (w_addr_chg) begin
          w_latch_addr = 1'b1;
          w_lat_nxt    = LAT_INIT;
        end else if (r_lat_cnt <= 3'd1) begin
          w_state_nxt = ST_DRIVE;
        end else begin
          w_lat_nxt = r_lat_cnt - 3'd1;
        end
      end
      ST_DRIVE: begin
        if (!w_ce) begin
          w_state_nxt = ST_IDLE;
        end else if (w_we) begin
          w_state_nxt  = ST_WRITE;
          w_capture    = 1'b1;
          w_latch_addr = 1'b1;
        end else if (!w_oe) begin
          w_state_nxt = ST_IDLE;
        end else if (w_addr_chg) begin
          w_state_nxt  = ST_READ;
          w_latch_addr = 1'b1;
          w_lat_nxt    = LAT_INIT;
        end else begin
          w_state_nxt = ST_DRIVE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // The bus is enabled one edge after DRIVE entry, so every latency lands at request+READ_LAT+1.
  assign w_drive_entry = (w_state_nxt == ST_DRIVE) && (r_state != ST_DRIVE);
  assign w_drive_hold  = (w_state_nxt == ST_DRIVE) && (r_state == ST_DRIVE);

  // Control state, captured write word, lane enables and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_lat_cnt  <= 3'd0;
      r_addr     <= '0;
      r_wdata    <= 16'h0000;
      r_wub_n    <= 1'b1;
      r_wlb_n    <= 1'b1;
      r_oe_hi    <= 1'b0;
      r_oe_lo    <= 1'b0;
      r_rd_count <= 16'h0000;
      r_wr_count <= 16'h0000;
    end else begin
      r_state   <= w_state_nxt;
      r_lat_cnt <= w_lat_nxt;
      r_oe_hi   <= w_drive_hold & ~SRAM_UB_N;
      r_oe_lo   <= w_drive_hold & ~SRAM_LB_N;
      if (w_latch_addr) r_addr <= w_addr;
      if (w_capture) begin
        r_wdata <= SRAM_DQ;
        r_wub_n <= SRAM_UB_N;
        r_wlb_n <= SRAM_LB_N;
      end
      if (w_commit && (r_wr_count != 16'hFFFF)) r_wr_count <= r_wr_count + 16'd1;
      if (w_drive_entry && (r_rd_count != 16'hFFFF)) r_rd_count <= r_rd_count + 16'd1;
    end
  end

  // Storage array (never cleared) and registered read word.
  always_ff @(posedge clk) begin
    if (w_commit && !r_wub_n) r_mem[r_addr][15:8] <= r_wdata[15:8];
    if (w_commit && !r_wlb_n) r_mem[r_addr][7:0]  <= r_wdata[7:0];
    r_dq <= r_mem[r_addr];
  end

  assign SRAM_DQ[15:8] = r_oe_hi ? r_dq[15:8] : 8'hzz;
  assign SRAM_DQ[7:0]  = r_oe_lo ? r_dq[7:0]  : 8'hzz;
  assign rd_count      = r_rd_count;
  assign wr_count      = r_wr_count;

`ifdef SRAM_RESP_CHECK_EN
  logic r_proto_err;
  logic w_proto_viol;

  assign w_proto_viol = (w_ce && w_we && w_oe)
                      || ((r_state == ST_WRITE) && w_ce && w_we && w_addr_chg)
                      || (w_ce && !w_we && w_oe && SRAM_UB_N && SRAM_LB_N);

  // Sticky protocol-violation flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_proto_err <= 1'b0;
    end else begin
      r_proto_err <= r_proto_err | w_proto_viol;
    end
  end

  assign proto_err = r_proto_err;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: randomized transactions against a word-array model.
// Undriven bus bits are pulled up, so a high-Z lane reads back as 8'hFF.
module tb_sram_responder;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] addr;
  logic        ub_n, lb_n, we_n, ce_n, oe_n;
  logic [15:0] tb_dq;
  logic        tb_oe;
  wire  [15:0] dq_bus;
  wire  [15:0] rd_count;
  wire  [15:0] wr_count;
  wire         proto_err;

  int          checks;
  int          errors;
  logic [15:0] mem_m [0:4095];
  logic [15:0] exp_rd;
  logic [15:0] exp_wr;
  logic        exp_proto;

  assign dq_bus = tb_oe ? tb_dq : 16'hzzzz;
  for (genvar g = 0; g < 16; g++) begin : g_pull
    pullup pu (dq_bus[g]);
  end

  sram_responder #(.MEM_AW(12), .READ_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .SRAM_DQ(dq_bus), .SRAM_ADDR(addr),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .rd_count(rd_count), .wr_count(wr_count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; ub_n = 1'b0; lb_n = 1'b0; tb_oe = 1'b0;
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [15:0] exp_word(input logic [17:0] a, input logic ub, input logic lb);
    logic [15:0] w;
    w = mem_m[a[11:0]];
    return {ub ? 8'hFF : w[15:8], lb ? 8'hFF : w[7:0]};
  endfunction

  // Write with `hold` active cycles; junk data on all but the last so only the last word counts.
  task automatic do_write(input logic [17:0] a, input logic [15:0] d, input logic ub, input logic lb, input int hold);
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; addr = a; ub_n = ub; lb_n = lb; tb_oe = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tb_dq = (i == hold - 1) ? d : 16'($urandom);
      tick();
    end
    idle_bus();
    tick();
    if (!ub) mem_m[a[11:0]][15:8] = d[15:8];
    if (!lb) mem_m[a[11:0]][7:0]  = d[7:0];
    exp_wr = sat_inc(exp_wr);
  endtask

  // Read request; returns AND of bus during latency, data, data one cycle later, bus after release.
  task automatic read_txn(input logic [17:0] a, input logic ub, input logic lb,
                          output logic [15:0] early, output logic [15:0] d,
                          output logic [15:0] d2, output logic [15:0] rel);
    ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; addr = a; ub_n = ub; lb_n = lb; tb_oe = 1'b0;
    early = 16'hFFFF;
    for (int i = 0; i <= LAT; i++) begin
      tick();
      early = early & dq_bus;
    end
    tick(); d = dq_bus;
    tick(); d2 = dq_bus;
    idle_bus();
    tick(); rel = dq_bus;
    exp_rd = sat_inc(exp_rd);
  endtask

  task automatic test_reset();
    rst = 1'b0; idle_bus(); addr = 18'h0; tb_dq = 16'h0;
    tick(); tick();
    checks++; if (dq_bus !== 16'hFFFF) begin errors++; $display("FAIL reset_dq got %h want ffff", dq_bus); end
    checks++; if (rd_count !== 16'h0) begin errors++; $display("FAIL reset_rd got %h want 0000", rd_count); end
    checks++; if (wr_count !== 16'h0) begin errors++; $display("FAIL reset_wr got %h want 0000", wr_count); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto got %b want 0", proto_err); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    logic [15:0] e, d, d2, r;
    do_write(18'h005, 16'hA55A, 1'b0, 1'b0, 1);
    read_txn(18'h005, 1'b0, 1'b0, e, d, d2, r);
    checks++; if (e !== 16'hFFFF) begin errors++; $display("FAIL wr_early got %h want ffff", e); end
    checks++; if (d !== 16'hA55A) begin errors++; $display("FAIL wr_data got %h want a55a", d); end
    checks++; if (d2 !== 16'hA55A) begin errors++; $display("FAIL wr_stable got %h want a55a", d2); end
    checks++; if (r !== 16'hFFFF) begin errors++; $display("FAIL wr_release got %h want ffff", r); end
    checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL wr_count1 got %h want 0001", wr_count); end
    checks++; if (rd_count !== 16'd1) begin errors++; $display("FAIL rd_count1 got %h want 0001", rd_count); end
  endtask

  task automatic test_byte_mask();
    logic [15:0] e, d, d2, r;
    do_write(18'h010, 16'h1234, 1'b0, 1'b0, 1);
    do_write(18'h010, 16'hFFFF, 1'b1, 1'b0, 2);
    read_txn(18'h010, 1'b0, 1'b0, e, d, d2, r);
    checks++; if (d !== 16'h12FF) begin errors++; $display("FAIL mask_ub got %h want 12ff", d); end
    do_write(18'h011, 16'h5A3C, 1'b0, 1'b0, 1);
    do_write(18'h011, 16'h0000, 1'b1, 1'b1, 1);
    read_txn(18'h011, 1'b0, 1'b1, e, d, d2, r);
    checks++; if (d !== 16'h5AFF) begin errors++; $display("FAIL mask_rd_lb got %h want 5aff", d); end
    read_txn(18'h011, 1'b1, 1'b0, e, d, d2, r);
    checks++; if (d !== 16'hFF3C) begin errors++; $display("FAIL mask_rd_ub got %h want ff3c", d); end
    checks++; if (wr_count !== exp_wr) begin errors++; $display("FAIL mask_wr_count got %h want %h", wr_count, exp_wr); end
  endtask

  task automatic test_addr_change();
    logic [15:0] e;
    do_write(18'h020, 16'h4C21, 1'b0, 1'b0, 1);
    do_write(18'h021, 16'h3A96, 1'b0, 1'b0, 1);
    ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; addr = 18'h020;
    tick();
    e = dq_bus;
    addr = 18'h021;
    for (int i = 0; i <= LAT; i++) begin
      tick();
      e = e & dq_bus;
    end
    checks++; if (e !== 16'hFFFF) begin errors++; $display("FAIL chg_early got %h want ffff", e); end
    tick();
    checks++; if (dq_bus !== 16'h3A96) begin errors++; $display("FAIL chg_data got %h want 3a96", dq_bus); end
    idle_bus();
    tick();
    exp_rd = sat_inc(exp_rd);
    checks++; if (rd_count !== exp_rd) begin errors++; $display("FAIL chg_rd_count got %h want %h", rd_count, exp_rd); end
  endtask

  task automatic test_alias();
    logic [15:0] e, d, d2, r;
    do_write(18'h1005, 16'hC3A5, 1'b0, 1'b0, 1);
    read_txn(18'h005, 1'b0, 1'b0, e, d, d2, r);
    checks++; if (d !== 16'hC3A5) begin errors++; $display("FAIL alias_data got %h want c3a5", d); end
  endtask

  task automatic test_random();
    logic [15:0] e, d, d2, r, xp;
    logic [17:0] a;
    logic        ub, lb;
    for (int i = 0; i < 32; i++) do_write(18'h100 + 18'(i), 16'($urandom), 1'b0, 1'b0, 1);
    for (int n = 0; n < 40; n++) begin
      a = {6'($urandom_range(0, 63)), 12'h100 + 12'($urandom_range(0, 31))};
      if ($urandom_range(0, 1) == 0) begin
        do_write(a, 16'($urandom), 1'($urandom), 1'($urandom), $urandom_range(1, 3));
        checks++; if (wr_count !== exp_wr) begin errors++; $display("FAIL rnd_wr_count got %h want %h", wr_count, exp_wr); end
      end else begin
        ub = 1'($urandom);
        lb = ub ? 1'b0 : 1'($urandom);
        xp = exp_word(a, ub, lb);
        read_txn(a, ub, lb, e, d, d2, r);
        checks++; if (e !== 16'hFFFF) begin errors++; $display("FAIL rnd_early got %h want ffff", e); end
        checks++; if (d !== xp) begin errors++; $display("FAIL rnd_data addr %h got %h want %h", a, d, xp); end
        checks++; if (d2 !== xp) begin errors++; $display("FAIL rnd_stable got %h want %h", d2, xp); end
        checks++; if (r !== 16'hFFFF) begin errors++; $display("FAIL rnd_release got %h want ffff", r); end
        checks++; if (rd_count !== exp_rd) begin errors++; $display("FAIL rnd_rd_count got %h want %h", rd_count, exp_rd); end
      end
    end
    checks++; if (proto_err !== exp_proto) begin errors++; $display("FAIL rnd_proto got %b want %b", proto_err, exp_proto); end
  endtask

  task automatic test_contention();
    logic [15:0] e, d, d2, r;
    do_write(18'h030, 16'h0F0F, 1'b0, 1'b0, 1);
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b0; addr = 18'h030; ub_n = 1'b0; lb_n = 1'b0;
    tb_dq = 16'h7E81; tb_oe = 1'b1;
    tick(); tick();
    checks++; if (dq_bus !== 16'h7E81) begin errors++; $display("FAIL cont_bus got %h want 7e81", dq_bus); end
    idle_bus();
    tick();
    mem_m[12'h030] = 16'h7E81;
    exp_wr = sat_inc(exp_wr);
`ifdef SRAM_RESP_CHECK_EN
    exp_proto = 1'b1;
`endif
    checks++; if (dq_bus !== 16'hFFFF) begin errors++; $display("FAIL cont_release got %h want ffff", dq_bus); end
    checks++; if (wr_count !== exp_wr) begin errors++; $display("FAIL cont_wr_count got %h want %h", wr_count, exp_wr); end
    checks++; if (proto_err !== exp_proto) begin errors++; $display("FAIL cont_proto got %b want %b", proto_err, exp_proto); end
    read_txn(18'h030, 1'b0, 1'b0, e, d, d2, r);
    checks++; if (d !== 16'h7E81) begin errors++; $display("FAIL cont_data got %h want 7e81", d); end
  endtask

  task automatic test_saturation();
    force dut.r_wr_count = 16'hFFFE;
    #1;
    release dut.r_wr_count;
    exp_wr = 16'hFFFE;
    do_write(18'h050, 16'h1357, 1'b0, 1'b0, 1);
    checks++; if (wr_count !== 16'hFFFF) begin errors++; $display("FAIL sat_first got %h want ffff", wr_count); end
    do_write(18'h051, 16'h2468, 1'b0, 1'b0, 1);
    checks++; if (wr_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want ffff", wr_count); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] e, d, d2, r;
    do_write(18'h040, 16'h2468, 1'b0, 1'b0, 1);
    ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; addr = 18'h040;
    repeat (LAT + 2) tick();
    checks++; if (dq_bus !== 16'h2468) begin errors++; $display("FAIL rstd_pre got %h want 2468", dq_bus); end
    rst = 1'b0;
    #1;
    exp_rd = 16'h0; exp_wr = 16'h0; exp_proto = 1'b0;
    checks++; if (dq_bus !== 16'hFFFF) begin errors++; $display("FAIL rstd_dq got %h want ffff", dq_bus); end
    checks++; if (rd_count !== 16'h0) begin errors++; $display("FAIL rstd_rd got %h want 0000", rd_count); end
    checks++; if (wr_count !== 16'h0) begin errors++; $display("FAIL rstd_wr got %h want 0000", wr_count); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rstd_proto got %b want 0", proto_err); end
    idle_bus();
    tick();
    rst = 1'b1;
    tick();
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; addr = 18'h040; tb_dq = 16'h9999; tb_oe = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    idle_bus();
    #1;
    checks++; if (dq_bus !== 16'hFFFF) begin errors++; $display("FAIL rstw_dq got %h want ffff", dq_bus); end
    checks++; if (wr_count !== 16'h0) begin errors++; $display("FAIL rstw_wr got %h want 0000", wr_count); end
    tick();
    rst = 1'b1;
    tick();
    read_txn(18'h040, 1'b0, 1'b0, e, d, d2, r);
    checks++; if (d !== 16'h2468) begin errors++; $display("FAIL rstw_word got %h want 2468", d); end
    checks++; if (wr_count !== exp_wr) begin errors++; $display("FAIL rstw_wr_after got %h want %h", wr_count, exp_wr); end
    checks++; if (rd_count !== exp_rd) begin errors++; $display("FAIL rstw_rd_after got %h want %h", rd_count, exp_rd); end
  endtask

  initial begin
    checks = 0; errors = 0;
    exp_rd = 16'h0; exp_wr = 16'h0; exp_proto = 1'b0;
    test_reset();
    test_write_read();
    test_byte_mask();
    test_addr_change();
    test_alias();
    test_random();
    test_contention();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
# sram_responder

Clocked, synthesizable model of the external 16-bit asynchronous SRAM that the MEM stage's SRAM controller drives. It sits on the far side of the `SRAM_DQ`/`SRAM_ADDR`/`SRAM_*_N` pins and responds to controller accesses. Reads are answered after a programmable latency, and writes are committed with byte-lane masking. It lets the pipeline's SRAM freeze/handshake path be exercised in simulation and on FPGA without the physical chip.

## Interface
- `MEM_AW`, 12: implemented address bits; the array holds 2^MEM_AW 16-bit words.
- `READ_LAT`, 2: clock cycles from a sampled read request to `SRAM_DQ` being driven; legal range 0..7.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- `SRAM_DQ` inout 16: bidirectional data bus; driven only in DRIVE state, otherwise high-Z.
- `SRAM_ADDR` in 18: word address; only bits [MEM_AW-1:0] are used.
- `SRAM_UB_N` in 1: upper byte lane enable, active-low.
- `SRAM_LB_N` in 1: lower byte lane enable, active-low.
- `SRAM_WE_N` in 1: write enable, active-low.
- `SRAM_CE_N` in 1: chip enable, active-low.
- `SRAM_OE_N` in 1: output enable, active-low.
- `rd_count` out 16: completed read accesses, saturating.
- `wr_count` out 16: committed writes, saturating.
- `proto_err` out 1: sticky protocol-violation flag (see Configuration).

## Operation
- All pin inputs are sampled on the rising `clk` edge. There is no combinational path from inputs to `SRAM_DQ`.
- States: IDLE, WRITE, READ, DRIVE.
- IDLE:
  - CE_N=0 and WE_N=0 → WRITE.
  - CE_N=0, WE_N=1, OE_N=0 → READ, with `lat_cnt` loaded to READ_LAT. If READ_LAT=0, go directly to DRIVE.
  - Any other combination stays in IDLE.
- WRITE:
  - Each cycle with WE_N=0 and CE_N=0, capture address, DQ, UB_N and LB_N.
  - On the first sample with WE_N=1 or CE_N=1, commit the last captured word to the array, increment `wr_count`, and return to IDLE.
  - Lane masking: the upper byte is written only if the captured UB_N=0, and the lower byte only if LB_N=0. If both are 1, no array change occurs but the write is still counted.
- READ:
  - `lat_cnt` decrements each cycle.
  - If the address changes, reload `lat_cnt` and stay in READ.
  - At 0 → DRIVE.
  - CE_N=1 or OE_N=1 → IDLE.
  - WE_N=0 → WRITE (the read is abandoned).
- DRIVE:
  - `SRAM_DQ` = array word at the latched address; each lane is high-Z when its UB_N/LB_N is 1.
  - `rd_count` increments once on entry.
  - An address change → READ (bus released) with the latency reloaded.
  - CE_N=1 or OE_N=1 → IDLE.
  - WE_N=0 → WRITE.
- Address bits above MEM_AW are ignored, so addresses alias modulo 2^MEM_AW.
- Counters saturate at 16'hFFFF; they do not wrap.
- The array is not cleared by reset.

## Timing
- Reset (rst=0, immediate and asynchronous):
  - state=IDLE, `SRAM_DQ`=16'hzzzz, `lat_cnt`=0.
  - `rd_count`=0, `wr_count`=0, `proto_err`=0.
  - A reset mid-write discards the uncommitted word.
- Read latency: with a request sampled at edge N, DQ is valid after edge N+READ_LAT+1 and stays stable while the address, CE_N and OE_N are held.
- Release: DQ returns to high-Z after the first edge that samples CE_N=1, OE_N=1, WE_N=0, or an address change.
- Write-to-read: a word committed at edge M is readable by a request sampled at edge M or later. The array update precedes the read-address sample in the same edge.
- Simultaneous WE_N=0 and OE_N=0: write has priority and DQ is never driven, which avoids bus contention.

## Configuration
- `SRAM_RESP_CHECK_EN` defined: a protocol checker sets `proto_err` (sticky until reset) on any of these:
  - WE_N=0 and OE_N=0 sampled together with CE_N=0.
  - Address change while in WRITE.
  - UB_N=LB_N=1 during a sampled read request.
- `SRAM_RESP_CHECK_EN` undefined: the checker is not compiled and `proto_err` is tied to 0. All other behaviour is identical.

## Test plan
- **Write then read:** write 16'hA55A to address 0x005 with both lanes enabled, deassert WE_N, then read 0x005 with READ_LAT=2 → DQ=16'hA55A valid 3 edges after the request; `wr_count`=1, `rd_count`=1.
- **Byte masking:** write 16'h1234 to 0x010, then write 16'hFFFF with UB_N=1 → a read returns 16'h12FF. A read with LB_N=1 drives 16'h12zz.
- **Address change mid-read:** request 0x020, then switch to 0x021 during the latency count → DQ stays high-Z until READ_LAT+1 edges after the change, then shows mem[0x021]; `rd_count` increments once.
- **Aliasing and saturation:** write to 0x1005 with MEM_AW=12 → the read of 0x005 returns that data. Preload `wr_count`=16'hFFFE via two extra writes → it holds at 16'hFFFF.
- **Contention and checker:** assert WE_N=0 and OE_N=0 with CE_N=0 → DQ remains high-Z and the write commits. `proto_err`=1 with `SRAM_RESP_CHECK_EN` defined, 0 without.
- **Reset mid-operation:** pulse rst low during DRIVE and again during WRITE → DQ is high-Z immediately, counters read 0, and the interrupted write leaves the target word unchanged.
